// File: rtl/fasm_sfifo.sv
// Single-clock FIFO: 2^AW x DW array, synchronous write, asynchronous read.
// Define FASM_SFIFO_OUTREG_EN to register dat_o/ack_o (one-cycle read latency).
module fasm_sfifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic [DW-1:0] xdat_i,
  input  logic          xstb_i,
  output logic          xack_o,
  input  logic          stb_i,
  output logic          ack_o,
  output logic [DW-1:0] dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   cnt_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_push;
  logic          w_pop;

  // Flags come from registered pointers only, never from this cycle's requests.
  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign cnt_o   = r_wptr - r_rptr;

  assign w_push  = xstb_i & ~full_o;
  assign w_pop   = stb_i & ~empty_o;
  assign xack_o  = w_push;

  // NOTE: the storage array has no reset; only the pointers define valid data.
  always_ff @(posedge clk_i) begin
    if (w_push && !clr_i) r_mem[r_wptr[AW-1:0]] <= xdat_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clr_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

`ifdef FASM_SFIFO_OUTREG_EN
  logic [DW-1:0] r_dat;
  logic          r_ack;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_dat <= '0;
      r_ack <= 1'b0;
    end else if (clr_i) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_pop;
      if (w_pop) r_dat <= r_mem[r_rptr[AW-1:0]];
    end
  end

  assign dat_o = r_dat;
  assign ack_o = r_ack;
`else
  // Show-ahead: the head word is presented before it is consumed.
  assign dat_o = r_mem[r_rptr[AW-1:0]];
  assign ack_o = w_pop;
`endif

endmodule

// File: tb/tb_fasm_sfifo.sv
// Self-checking bench for fasm_sfifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fasm_sfifo;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          clr_i = 1'b0;
  logic [DW-1:0] xdat_i = '0;
  logic          xstb_i = 1'b0;
  logic          xack_o;
  logic          stb_i = 1'b0;
  logic          ack_o;
  logic [DW-1:0] dat_o;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   cnt_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model[$];

  fasm_sfifo #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .xdat_i(xdat_i), .xstb_i(xstb_i), .xack_o(xack_o),
    .stb_i(stb_i), .ack_o(ack_o), .dat_o(dat_o),
    .full_o(full_o), .empty_o(empty_o), .cnt_o(cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus, entered and left at a falling edge.
  task automatic cycle(input logic push, input logic pop, input logic clr, input logic [DW-1:0] d);
    int sz;
    bit pacc, qacc;
    logic [DW-1:0] head;
    sz   = model.size();
    pacc = push && (sz < DEPTH);
    qacc = pop && (sz > 0);
    head = (sz > 0) ? model[0] : '0;
    xstb_i = push; stb_i = pop; clr_i = clr; xdat_i = d;
    #1;
    check("empty", empty_o, sz == 0);
    check("full", full_o, sz == DEPTH);
    check("cnt", cnt_o, sz);
    check("xack", xack_o, pacc);
`ifndef FASM_SFIFO_OUTREG_EN
    check("ack", ack_o, qacc);
    if (sz > 0) check("dat", dat_o, head);
`endif
    @(posedge clk_i);
    if (clr) model.delete();
    else begin
      if (qacc) void'(model.pop_front());
      if (pacc) model.push_back(d);
    end
`ifdef FASM_SFIFO_OUTREG_EN
    #1;
    check("ack_reg", ack_o, qacc && !clr);
    if (qacc && !clr) check("dat_reg", dat_o, head);
`endif
    @(negedge clk_i);
    xstb_i = 1'b0; stb_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_empty"}, empty_o, model.size() == 0);
    check({tag, "_full"}, full_o, model.size() == DEPTH);
    check({tag, "_cnt"}, cnt_o, model.size());
    check({tag, "_ack"}, ack_o, 1'b0);
  endtask

  initial begin
    // Reset state
    #1;
    check_idle("rst");
`ifdef FASM_SFIFO_OUTREG_EN
    check("rst_dat", dat_o, 0);
`endif
    xstb_i = 1'b1; #1;
    check("rst_xack", xack_o, 1'b1);
    xstb_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_idle("idle");

    // Fill to full, reject 17th push, push+pop at full
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, DW'(i));
    check("full_cnt", cnt_o, DEPTH);
    cycle(1'b1, 1'b0, 1'b0, 8'hAA);
    cycle(1'b1, 1'b1, 1'b0, 8'h77);
    check("full_pp_cnt", cnt_o, DEPTH - 1);
    while (model.size() > 0) cycle(1'b0, 1'b1, 1'b0, '0);
    check_idle("drained");

    // Push+pop at empty
    cycle(1'b1, 1'b1, 1'b0, 8'h33);
    check("empty_pp_cnt", cnt_o, 1);
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Wrap-around with occupancy held at 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, DW'(i * 3));
    for (int i = 5; i < 45; i++) begin
      cycle(1'b1, 1'b1, 1'b0, DW'(i * 3));
      check("wrap_cnt", cnt_o, 5);
    end
    while (model.size() > 0) cycle(1'b0, 1'b1, 1'b0, '0);

    // Flush with 7 queued, concurrent push and pop discarded
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
    cycle(1'b1, 1'b1, 1'b1, 8'h99);
    check_idle("flush");
    cycle(1'b1, 1'b0, 1'b0, 8'h5C);
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 2), DW'($urandom));
    while (model.size() > 0) cycle(1'b0, 1'b1, 1'b0, '0);

    // Asynchronous reset between edges with 3 queued
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'hC0 + i));
    check("pre_rst_cnt", cnt_o, 3);
    #2 rst_i = 1'b0;
    model.delete();
    #1;
    check_idle("async_rst");
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_idle("post_rst");
    cycle(1'b1, 1'b0, 1'b0, 8'h5A);
    cycle(1'b1, 1'b1, 1'b0, 8'hA5);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
